// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, instruction field positions, fetch FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RD_W    = 3;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS1_W   = 3;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned RS2_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_field_split.sv
// Combinational splitter of a raw instruction into its register/opcode fields.
module inst_field_split
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] inst,
  output logic [OPC_W-1:0]  opcode,
  output logic [RD_W-1:0]   rd,
  output logic [RS1_W-1:0]  rs1,
  output logic [RS2_W-1:0]  rs2
);

  // Low bits carry no field; kept named so they are visibly intentional.
  logic unused_low_bits;

  assign opcode          = inst[OPC_LSB +: OPC_W];
  assign rd              = inst[RD_LSB  +: RD_W];
  assign rs1             = inst[RS1_LSB +: RS1_W];
  assign rs2             = inst[RS2_LSB +: RS2_W];
  assign unused_low_bits = ^inst[RS2_LSB-1:0];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads the program ROM and presents one
// registered instruction slot to the decoder over valid/ready.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W       = cpu_pkg::DATA_W,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          STOP_ON_WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [OPC_W-1:0]  opcode,
  output logic [RD_W-1:0]   rd,
  output logic [RS1_W-1:0]  rs1,
  output logic [RS2_W-1:0]  rs2,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              slot_free;
  logic              load;

  // A load happens whenever fetching, the slot can accept, and no redirect wins.
  assign slot_free = !valid_q || inst_ready;
  assign load      = (state_q == FETCH) && slot_free && !redirect_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; redirect has priority over start and wrap detection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!redirect_valid && start) state_d = FETCH;
      FETCH:   if (load && STOP_ON_WRAP && (pc_q == '1)) state_d = HALT;
      HALT:    if (redirect_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Slot and PC next values: redirect flushes, load fills, ready alone drains.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (load) begin
      inst_d    = rom_data;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + ADDR_W'(1);
    end else if (inst_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= ADDR_W'(RESET_PC);
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign rom_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = (state_q == HALT);

  inst_field_split #(.DATA_W(DATA_W)) u_split (
    .inst   (inst_q),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one instance halting on wrap, one wrapping.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect_valid, inst_ready;
  logic [7:0]  redirect_pc;
  logic [15:0] mem [256];

  logic [7:0]  ra1, ipc1, ra0, ipc0;
  logic [15:0] rd1, inst1, rd0, inst0;
  logic        v1, h1, v0, h0;
  logic [3:0]  opc1, opc0;
  logic [2:0]  rdf1, rs1_1, rs2_1, rdf0, rs1_0, rs2_0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rd1 = mem[ra1];
  assign rd0 = mem[ra0];

  inst_fetch #(.STOP_ON_WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .rom_addr(ra1), .rom_data(rd1), .inst_valid(v1),
    .inst_ready(inst_ready), .inst(inst1), .inst_pc(ipc1), .opcode(opc1),
    .rd(rdf1), .rs1(rs1_1), .rs2(rs2_1), .halted(h1)
  );

  inst_fetch #(.STOP_ON_WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .rom_addr(ra0), .rom_data(rd0), .inst_valid(v0),
    .inst_ready(inst_ready), .inst(inst0), .inst_pc(ipc0), .opcode(opc0),
    .rd(rdf0), .rs1(rs1_0), .rs2(rs2_0), .halted(h0)
  );

  typedef struct packed {
    logic        start;
    logic        redir;
    logic [7:0]  rpc;
    logic        ready;
    logic        valid;
    logic [15:0] inst;
    logic [7:0]  ipc;
    logic [7:0]  ra;
    logic [3:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [7:0] rp, input logic rdy);
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1111;
    mem[0] = 16'h0050;
    mem[1] = 16'h14C8;

    //          st   rv   rpc    rdy  v    inst      ipc    ra     opc rd rs1 rs2
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,16'h0000,8'h00,8'h00,4'd0,3'd0,3'd0,3'd0};
    vecs[1]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h0050,8'h00,8'h01,4'd0,3'd0,3'd1,3'd2};
    vecs[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h14C8,8'h01,8'h02,4'd1,3'd2,3'd3,3'd1};
    vecs[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,16'h14C8,8'h01,8'h02,4'd1,3'd2,3'd3,3'd1};
    vecs[4]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,16'h14C8,8'h01,8'h02,4'd1,3'd2,3'd3,3'd1};
    vecs[5]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,16'h14C8,8'h01,8'h02,4'd1,3'd2,3'd3,3'd1};
    vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h1111,8'h02,8'h03,4'd1,3'd0,3'd4,3'd2};
    vecs[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h1111,8'h03,8'h04,4'd1,3'd0,3'd4,3'd2};
    vecs[8]  = '{1'b0,1'b1,8'h10,1'b1,1'b0,16'h1111,8'h03,8'h10,4'd1,3'd0,3'd4,3'd2};
    vecs[9]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h1111,8'h10,8'h11,4'd1,3'd0,3'd4,3'd2};
    vecs[10] = '{1'b1,1'b0,8'h00,1'b1,1'b1,16'h1111,8'h11,8'h12,4'd1,3'd0,3'd4,3'd2};
    vecs[11] = '{1'b0,1'b0,8'h00,1'b1,1'b1,16'h1111,8'h12,8'h13,4'd1,3'd0,3'd4,3'd2};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("reset.valid",  32'(v1),    32'd0);
    chk("reset.inst",   32'(inst1), 32'h0);
    chk("reset.ipc",    32'(ipc1),  32'h0);
    chk("reset.ra",     32'(ra1),   32'h0);
    chk("reset.halted", 32'(h1),    32'd0);
    rst_n = 1'b1;

    // Basic fetch, backpressure, redirect, start-in-FETCH
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].start, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      step();
      chk($sformatf("vec%0d.valid", i),  32'(v1),    32'(vecs[i].valid));
      chk($sformatf("vec%0d.inst", i),   32'(inst1), 32'(vecs[i].inst));
      chk($sformatf("vec%0d.ipc", i),    32'(ipc1),  32'(vecs[i].ipc));
      chk($sformatf("vec%0d.ra", i),     32'(ra1),   32'(vecs[i].ra));
      chk($sformatf("vec%0d.opc", i),    32'(opc1),  32'(vecs[i].opc));
      chk($sformatf("vec%0d.rd", i),     32'(rdf1),  32'(vecs[i].rd));
      chk($sformatf("vec%0d.rs1", i),    32'(rs1_1), 32'(vecs[i].rs1));
      chk($sformatf("vec%0d.rs2", i),    32'(rs2_1), 32'(vecs[i].rs2));
      chk($sformatf("vec%0d.halted", i), 32'(h1),    32'd0);
    end

    // Wrap / halt
    drive(1'b0, 1'b1, 8'hFE, 1'b1);
    step();
    chk("wrap.redir.valid", 32'(v1),  32'd0);
    chk("wrap.redir.ra",    32'(ra1), 32'hFE);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("wrap.fe.valid", 32'(v1),   32'd1);
    chk("wrap.fe.ipc",   32'(ipc1), 32'hFE);
    step();
    chk("wrap.ff.ipc",    32'(ipc1), 32'hFF);
    chk("wrap.ff.valid",  32'(v1),   32'd1);
    chk("wrap.ff.halted", 32'(h1),   32'd1);
    chk("wrap.ff.ra",     32'(ra1),  32'h00);
    chk("nowrap.ff.halted", 32'(h0), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("wrap.stall.valid", 32'(v1),   32'd1);
    chk("wrap.stall.ipc",   32'(ipc1), 32'hFF);
    chk("nowrap.stall.ipc", 32'(ipc0), 32'hFF);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("wrap.drain.valid",  32'(v1),    32'd0);
    chk("wrap.drain.halted", 32'(h1),    32'd1);
    chk("wrap.drain.ra",     32'(ra1),   32'h00);
    chk("nowrap.next.valid", 32'(v0),    32'd1);
    chk("nowrap.next.ipc",   32'(ipc0),  32'h00);
    chk("nowrap.next.inst",  32'(inst0), 32'h0050);
    chk("nowrap.halted",     32'(h0),    32'd0);
    step();
    chk("wrap.halt.valid", 32'(v1), 32'd0);
    chk("wrap.halt.ra",    32'(ra1), 32'h00);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    step();
    chk("resume.redir.valid",  32'(v1), 32'd0);
    chk("resume.redir.halted", 32'(h1), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("resume.valid", 32'(v1),    32'd1);
    chk("resume.inst",  32'(inst1), 32'h0050);
    chk("resume.ipc",   32'(ipc1),  32'h00);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step();
    chk("mid.ipc",   32'(ipc1), 32'h05);
    chk("mid.valid", 32'(v1),   32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst.valid",   32'(v1),  32'd0);
    chk("rst.halted",  32'(h1),  32'd0);
    chk("rst.ra",      32'(ra1), 32'h00);
    chk("rst.valid0",  32'(v0),  32'd0);
    chk("rst.ra0",     32'(ra0), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle%0d.valid", i), 32'(v1),  32'd0);
      chk($sformatf("idle%0d.ra", i),    32'(ra1), 32'h00);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rstart.valid0", 32'(v1), 32'd0);
    step();
    chk("rstart.valid", 32'(v1),   32'd1);
    chk("rstart.ipc",   32'(ipc1), 32'h00);

    // Redirect while IDLE, then start
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h20, 1'b1);
    step();
    chk("idlered.valid",  32'(v1),  32'd0);
    chk("idlered.ra",     32'(ra1), 32'h20);
    chk("idlered.halted", 32'(h1),  32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("idlered.stay.valid", 32'(v1),  32'd0);
    chk("idlered.stay.ra",    32'(ra1), 32'h20);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("idlered.start.valid", 32'(v1), 32'd0);
    step();
    chk("idlered.first.valid", 32'(v1),   32'd1);
    chk("idlered.first.ipc",   32'(ipc1), 32'h20);
    chk("idlered.first.ra",    32'(ra1),  32'h21);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
